writeback_stage: RTL and testbench
==================================

Name: writeback_stage

Overview:
- Final pipeline stage of the RV64 core; the write side of the register file that the decode stage reads.
- Captures MEM-stage results in a MEM/WB pipeline register and selects ALU result or load data.
- For loads, performs byte-lane alignment and sign/zero extension.
- Drives the register-file write port (rd / WriteData / reg_write), a forwarding tap for hazard logic, and a retired-instruction counter.

Parameters:
- XLEN, 64, datapath width (only 64 supported).
- CNT_W, 64, retire counter width.

Ports:
- clk  input  1  core clock.
- reset  input  1  asynchronous, active-high reset.
- hold  input  1  hazard/stall request; blocks capture of a new instruction.
- in_valid  input  1  MEM stage presents an instruction.
- in_ready  output  1  stage accepts this cycle; equals ~hold.
- in_rd  input  5  destination register.
- in_regwrite  input  1  instruction writes rd.
- in_memtoreg  input  1  1 = load data, 0 = ALU result.
- in_funct3  input  3  load size/sign encoding.
- in_alu_result  input  64  ALU result; for loads, the effective address.
- in_mem_rdata  input  64  aligned 64-bit doubleword returned by data memory.
- rd  output  5  register-file write address.
- WriteData  output  64  register-file write data.
- reg_write  output  1  register-file write enable.
- fwd_valid  output  1  stage holds a valid writing instruction (for forwarding/hazard compare).
- load_fault  output  1  illegal load funct3 seen at the output stage.
- retire_count  output  CNT_W  number of instructions retired.

Behaviour:
- Asynchronous reset: stage valid 0, rd 0, WriteData 0, reg_write 0, fwd_valid 0, load_fault 0, retire_count 0. in_ready follows ~hold.
- Capture: on a rising edge with in_valid & in_ready, register all in_* fields and set stage valid.
- Drain: the stage always drains in one cycle.
  - If no capture occurs, stage valid clears on the next edge.
  - hold never freezes an occupied stage.
- Latency: exactly one cycle from accepted input to the reg_write pulse.
- One write pulse per instruction: no duplicate writes, no missed writes.
- reg_write = stage valid & regwrite & (rd != 0); x0 is never written.
- fwd_valid equals reg_write.
- WriteData: memtoreg=0 gives the registered ALU result. memtoreg=1 gives the load-extended value:
  - off = alu_result[2:0]; sh = in_mem_rdata >> (8*off), with zero-fill from the top.
  - funct3 000 LB: sign-extend sh[7:0].
  - 001 LH: sign-extend sh[15:0].
  - 010 LW: sign-extend sh[31:0].
  - 011 LD: sh.
  - 100 LBU: zero-extend sh[7:0].
  - 101 LHU: zero-extend sh[15:0].
  - 110 LWU: zero-extend sh[31:0].
  - 111: WriteData = 0, reg_write forced 0, load_fault = 1 for that cycle.
  - Misaligned access: no trap; bytes beyond the doubleword read as zero.
- funct3 is ignored when memtoreg = 0.
- Extraction is combinational from the registered fields; the write-port outputs are registered-stage values.
- Retire counter: increments by 1 for every instruction leaving the stage, including non-writing instructions and load_fault. It wraps modulo 2^CNT_W.
- Simultaneous events: capture and drain on the same edge gives back-to-back instructions and a continuous reg_write every cycle.
- hold=1 with in_valid=1: the input is not taken; the occupied stage still drains.
- Reset mid-operation: the in-flight instruction is discarded, with no write and no count.

Decomposition:
- Shared package riscv_pkg holds:
  - XLEN.
  - Load funct3 constants: F3_LB, F3_LH, F3_LW, F3_LD, F3_LBU, F3_LHU, F3_LWU.
  - A typedef struct mem_wb_t for the pipeline-register fields.
- Sub-module load_align (combinational): funct3, offset and rdata in; extended data and fault out. It is reused by any future load-forwarding path.

Test Plan:
- ALU write: in_rd=5, regwrite=1, memtoreg=0, alu_result=0x1234 -> next cycle rd=5, WriteData=0x1234, reg_write=1 for exactly 1 cycle, retire_count=1.
- x0 suppression: in_rd=0, regwrite=1, alu_result=0xFF -> reg_write=0, fwd_valid=0, retire_count still increments.
- Load extension with rdata=0x8070_6050_4030_2010:
  - LB with off=7 -> 0xFFFF_FFFF_FFFF_FF80.
  - LBU with off=7 -> 0x80.
  - LH with off=6 -> 0xFFFF_FFFF_FFFF_8070.
  - LW with off=4 -> 0xFFFF_FFFF_8070_6050.
  - LD with off=0 -> full value.
  - funct3=111 -> load_fault=1, reg_write=0.
- Hold behaviour: hold=1 with in_valid=1 for 3 cycles -> in_ready=0, no capture, the previously captured instruction writes once; release hold -> capture on the next edge.
- Back-to-back: 4 consecutive valid instructions (rd 1..4) -> reg_write high 4 consecutive cycles with matching rd/WriteData, retire_count=4.
- Async reset mid-stream: assert reset between edges while the stage is valid -> all outputs 0 immediately, no write after release, retire_count=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV64 definitions for the writeback path: width, load funct3
// encodings and the MEM/WB pipeline-register layout.
package riscv_pkg;

  localparam int XLEN = 64;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  typedef struct packed {
    logic [4:0]      rd;
    logic            regwrite;
    logic            memtoreg;
    logic [2:0]      funct3;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] mem_rdata;
  } mem_wb_t;

endpackage

// File: rtl/load_align.sv
// Combinational load extraction: shifts the addressed bytes down to lane 0
// and applies size/sign extension. Bytes past the doubleword read as zero.
module load_align
  import riscv_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [2:0]      off,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] data,
  output logic            fault
);

  logic [XLEN-1:0] sh;
  logic signed [7:0]  sh_b;
  logic signed [15:0] sh_h;
  logic signed [31:0] sh_w;

  always_comb begin
    sh    = rdata >> {off, 3'b000};
    sh_b  = signed'(sh[7:0]);
    sh_h  = signed'(sh[15:0]);
    sh_w  = signed'(sh[31:0]);
    data  = '0;
    fault = 1'b0;
    case (funct3)
      F3_LB:   data = XLEN'(sh_b);
      F3_LH:   data = XLEN'(sh_h);
      F3_LW:   data = XLEN'(sh_w);
      F3_LD:   data = sh;
      F3_LBU:  data = {{(XLEN-8){1'b0}},  sh[7:0]};
      F3_LHU:  data = {{(XLEN-16){1'b0}}, sh[15:0]};
      F3_LWU:  data = {{(XLEN-32){1'b0}}, sh[31:0]};
      default: fault = 1'b1;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// RV64 writeback stage: MEM/WB register, result select with load alignment,
// register-file write port, forwarding tap and retired-instruction counter.
module writeback_stage
  import riscv_pkg::*;
#(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hold,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_rd,
  input  logic             in_regwrite,
  input  logic             in_memtoreg,
  input  logic [2:0]       in_funct3,
  input  logic [XLEN-1:0]  in_alu_result,
  input  logic [XLEN-1:0]  in_mem_rdata,
  output logic [4:0]       rd,
  output logic [XLEN-1:0]  WriteData,
  output logic             reg_write,
  output logic             fwd_valid,
  output logic             load_fault,
  output logic [CNT_W-1:0] retire_count
);

  mem_wb_t          wb_p1;
  logic             vld_p1;
  logic             accept_p0;
  logic [XLEN-1:0]  ld_data_p1;
  logic             ld_fault_p1;
  logic [CNT_W-1:0] cnt_p1;

  assign in_ready  = ~hold;
  assign accept_p0 = in_valid & in_ready;

  // p0 -> p1: capture on accept; the stage empties every cycle regardless of hold
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      wb_p1  <= '0;
      cnt_p1 <= '0;
    end else begin
      vld_p1 <= accept_p0;
      if (accept_p0) begin
        wb_p1.rd         <= in_rd;
        wb_p1.regwrite   <= in_regwrite;
        wb_p1.memtoreg   <= in_memtoreg;
        wb_p1.funct3     <= in_funct3;
        wb_p1.alu_result <= in_alu_result;
        wb_p1.mem_rdata  <= in_mem_rdata;
      end
      if (vld_p1)
        cnt_p1 <= cnt_p1 + CNT_W'(1);
    end
  end

  load_align u_load_align (
    .funct3 (wb_p1.funct3),
    .off    (wb_p1.alu_result[2:0]),
    .rdata  (wb_p1.mem_rdata),
    .data   (ld_data_p1),
    .fault  (ld_fault_p1)
  );

  // p1 outputs: write port driven combinationally from the registered fields
  always_comb begin
    load_fault = vld_p1 & wb_p1.memtoreg & ld_fault_p1;
    reg_write  = vld_p1 & wb_p1.regwrite & (wb_p1.rd != 5'd0) & ~load_fault;
    fwd_valid  = reg_write;
    rd         = wb_p1.rd;
    WriteData  = wb_p1.memtoreg ? ld_data_p1 : wb_p1.alu_result;
  end

  assign retire_count = cnt_p1;

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: directed instructions push expected
// write-port results; a negedge monitor pops and compares on every output event.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        hold;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic        in_regwrite;
  logic        in_memtoreg;
  logic [2:0]  in_funct3;
  logic [63:0] in_alu_result;
  logic [63:0] in_mem_rdata;
  logic [4:0]  rd;
  logic [63:0] WriteData;
  logic        reg_write;
  logic        fwd_valid;
  logic        load_fault;
  logic [63:0] retire_count;

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] wd;
    logic        we;
    logic        flt;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   writes_seen = 0;
  logic [63:0] cnt_base;
  int   w_base;

  localparam logic [63:0] RDATA = 64'h8070_6050_4030_2010;

  writeback_stage #(.CNT_W(64)) dut (
    .clk(clk), .reset(reset), .hold(hold), .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_regwrite(in_regwrite), .in_memtoreg(in_memtoreg),
    .in_funct3(in_funct3), .in_alu_result(in_alu_result), .in_mem_rdata(in_mem_rdata),
    .rd(rd), .WriteData(WriteData), .reg_write(reg_write), .fwd_valid(fwd_valid),
    .load_fault(load_fault), .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write pulse or fault must match the oldest expectation.
  always @(negedge clk) begin
    if (reg_write === 1'b1 || load_fault === 1'b1) begin
      if (reg_write === 1'b1) writes_seen++;
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: rd=%0d wd=0x%0h we=%b flt=%b expected none",
                 rd, WriteData, reg_write, load_fault);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (e.we) chk("rd", 64'(rd), 64'(e.rd));
        chk("write_data", WriteData, e.wd);
        chk("reg_write", 64'(reg_write), 64'(e.we));
        chk("fwd_valid", 64'(fwd_valid), 64'(e.we));
        chk("load_fault", 64'(load_fault), 64'(e.flt));
      end
    end
  end

  task automatic drive(input logic [4:0] r, input logic rw, input logic m2r,
                       input logic [2:0] f3, input logic [63:0] alu, input logic [63:0] md);
    in_rd = r; in_regwrite = rw; in_memtoreg = m2r; in_funct3 = f3;
    in_alu_result = alu; in_mem_rdata = md;
  endtask

  // Issue one instruction through an accepting edge, optionally recording its expected result.
  task automatic issue(input logic [4:0] r, input logic rw, input logic m2r, input logic [2:0] f3,
                       input logic [63:0] alu, input logic [63:0] md, input logic push,
                       input logic [63:0] wd, input logic we, input logic flt);
    exp_t e;
    drive(r, rw, m2r, f3, alu, md);
    in_valid = 1'b1;
    if (push) begin
      e.rd = r; e.wd = wd; e.we = we; e.flt = flt;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; hold = 1'b0; in_valid = 1'b0;
    drive(5'd0, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0);
    #12;
    chk("reset_rd", 64'(rd), 64'd0);
    chk("reset_wd", WriteData, 64'd0);
    chk("reset_we", 64'(reg_write), 64'd0);
    chk("reset_fwd", 64'(fwd_valid), 64'd0);
    chk("reset_flt", 64'(load_fault), 64'd0);
    chk("reset_cnt", retire_count, 64'd0);
    chk("reset_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    idle(1);

    // ALU write
    issue(5'd5, 1'b1, 1'b0, 3'd0, 64'h1234, 64'd0, 1'b1, 64'h1234, 1'b1, 1'b0);
    idle(1);
    chk("alu_cnt", retire_count, 64'd1);

    // x0 is never written but still retires
    issue(5'd0, 1'b1, 1'b0, 3'd0, 64'hFF, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0);
    chk("x0_we", 64'(reg_write), 64'd0);
    chk("x0_fwd", 64'(fwd_valid), 64'd0);
    idle(1);
    chk("x0_cnt", retire_count, 64'd2);

    // Load extraction, issued back to back
    issue(5'd10, 1'b1, 1'b1, 3'b000, 64'h1007, RDATA, 1'b1, 64'hFFFF_FFFF_FFFF_FF80, 1'b1, 1'b0);
    issue(5'd11, 1'b1, 1'b1, 3'b100, 64'h1007, RDATA, 1'b1, 64'h80, 1'b1, 1'b0);
    issue(5'd12, 1'b1, 1'b1, 3'b001, 64'h1006, RDATA, 1'b1, 64'hFFFF_FFFF_FFFF_8070, 1'b1, 1'b0);
    issue(5'd13, 1'b1, 1'b1, 3'b010, 64'h1004, RDATA, 1'b1, 64'hFFFF_FFFF_8070_6050, 1'b1, 1'b0);
    issue(5'd14, 1'b1, 1'b1, 3'b011, 64'h1000, RDATA, 1'b1, RDATA, 1'b1, 1'b0);
    issue(5'd15, 1'b1, 1'b1, 3'b111, 64'h1000, RDATA, 1'b1, 64'd0, 1'b0, 1'b1);
    issue(5'd16, 1'b1, 1'b1, 3'b010, 64'h1006, RDATA, 1'b1, 64'h8070, 1'b1, 1'b0);
    issue(5'd17, 1'b1, 1'b1, 3'b101, 64'h1001, RDATA, 1'b1, 64'h3020, 1'b1, 1'b0);
    issue(5'd18, 1'b1, 1'b0, 3'b111, 64'hABCD, RDATA, 1'b1, 64'hABCD, 1'b1, 1'b0);
    idle(1);
    chk("load_cnt", retire_count, 64'd11);

    // Hold: occupied stage drains once, new input refused for 3 edges
    issue(5'd20, 1'b1, 1'b0, 3'd0, 64'hA0, 64'd0, 1'b1, 64'hA0, 1'b1, 1'b0);
    hold = 1'b1;
    in_valid = 1'b1;
    drive(5'd21, 1'b1, 1'b0, 3'd0, 64'hB1, 64'd0);
    #1;
    chk("hold_ready", 64'(in_ready), 64'd0);
    idle(3);
    chk("hold_cnt", retire_count, 64'd12);
    begin
      exp_t e;
      e.rd = 5'd21; e.wd = 64'hB1; e.we = 1'b1; e.flt = 1'b0;
      q.push_back(e);
    end
    hold = 1'b0;
    idle(1);
    in_valid = 1'b0;
    chk("release_we", 64'(reg_write), 64'd1);
    idle(1);
    chk("release_cnt", retire_count, 64'd13);

    // Back-to-back: four writes on consecutive cycles
    cnt_base = retire_count;
    w_base = writes_seen;
    for (int i = 1; i <= 4; i++)
      issue(5'(i), 1'b1, 1'b0, 3'd0, 64'h100 + 64'(i), 64'd0, 1'b1, 64'h100 + 64'(i), 1'b1, 1'b0);
    idle(1);
    chk("b2b_writes", 64'(writes_seen - w_base), 64'd4);
    chk("b2b_cnt", retire_count - cnt_base, 64'd4);

    // Asynchronous reset while the stage holds an instruction
    issue(5'd9, 1'b1, 1'b0, 3'd0, 64'hDEAD, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0);
    chk("pre_reset_we", 64'(reg_write), 64'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("arst_we", 64'(reg_write), 64'd0);
    chk("arst_fwd", 64'(fwd_valid), 64'd0);
    chk("arst_rd", 64'(rd), 64'd0);
    chk("arst_wd", WriteData, 64'd0);
    chk("arst_cnt", retire_count, 64'd0);
    idle(1);
    @(negedge clk);
    reset = 1'b0;
    idle(3);
    chk("post_reset_cnt", retire_count, 64'd0);
    chk("queue_empty", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
